// File: rtl/bus_arbiter.sv
// Two-requester burst arbiter: round-robin on ties, BURST_MAX beats per grant, registered beat output.
// Optional macro BUS_ARB_ADDR_CHECK_EN: beats to address 8'h3F are acked with err and not forwarded.
module bus_arb_lane (
  input  logic       own,
  input  logic       req,
  input  logic [7:0] addr,
  output logic       ack,
  output logic       err
);
  assign ack = own & req;
`ifdef BUS_ARB_ADDR_CHECK_EN
  assign err = ack & (addr == 8'h3F);
`else
  logic unused_addr;
  assign unused_addr = ^addr;
  assign err = 1'b0;
`endif
endmodule

module bus_arbiter #(
  parameter int BURST_MAX = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [7:0]  addr0,
  input  logic [15:0] data0,
  output logic        ack0,
  output logic        err0,
  input  logic        req1,
  input  logic [7:0]  addr1,
  input  logic [15:0] data1,
  output logic        ack1,
  output logic        err1,
  output logic        valid,
  output logic [7:0]  addr_out,
  output logic [15:0] data_out,
  output logic [1:0]  gnt
);
  localparam int         NREQ = 2;
  localparam logic [3:0] LAST = 4'(BURST_MAX - 1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t                      state, state_n, oth;
  logic [3:0]                  cnt, cnt_n;
  logic                        last_owner, cur, fwd;
  logic [NREQ-1:0]             req, own, ack, err;
  logic [NREQ-1:0][7:0]        addr;
  logic [NREQ-1:0][15:0]       data;

  assign req  = {req1, req0};
  assign addr = {addr1, addr0};
  assign data = {data1, data0};
  assign own  = {state == OWN1, state == OWN0};

  for (genvar i = 0; i < NREQ; i++) begin : g_lane
    bus_arb_lane u_lane (
      .own  (own[i]),
      .req  (req[i]),
      .addr (addr[i]),
      .ack  (ack[i]),
      .err  (err[i])
    );
  end

  assign {ack1, ack0} = ack;
  assign {err1, err0} = err;
  // Errored beats are consumed (acked, counted) but never reach the bus.
  assign fwd = |ack & ~|err;

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    cur     = (state == OWN1);
    oth     = cur ? OWN0 : OWN1;
    case (state)
      IDLE: begin
        // last_owner==1 means requester 0 wins a tie
        if (req[0] && (!req[1] || last_owner)) state_n = OWN0;
        else if (req[1])                       state_n = OWN1;
      end
      OWN0, OWN1: begin
        if (req[cur]) begin
          if (cnt == LAST) begin
            cnt_n = 4'd0;
            if (req[~cur]) state_n = oth;
          end else begin
            cnt_n = cnt + 4'd1;
          end
        end else begin
          state_n = req[~cur] ? oth : IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (state_n != state) cnt_n = 4'd0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      last_owner <= 1'b1;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (state_n == OWN0)      last_owner <= 1'b0;
      else if (state_n == OWN1) last_owner <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt      <= 2'b00;
      valid    <= 1'b0;
      addr_out <= 8'h00;
      data_out <= 16'h0000;
    end else begin
      gnt   <= {state_n == OWN1, state_n == OWN0};
      valid <= fwd;
      if (fwd) begin
        addr_out <= ack[1] ? addr[1] : addr[0];
        data_out <= ack[1] ? data[1] : data[0];
      end
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: expected beats queued per test, popped on each valid.
module tb_bus_arbiter;
  logic        clk = 1'b0, reset;
  logic        req0, req1, ack0, ack1, err0, err1, valid;
  logic [7:0]  addr0, addr1, addr_out;
  logic [15:0] data0, data1, data_out;
  logic [1:0]  gnt;

  always #5 clk = ~clk;

  bus_arbiter #(.BURST_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .addr0(addr0), .data0(data0), .ack0(ack0), .err0(err0),
    .req1(req1), .addr1(addr1), .data1(data1), .ack1(ack1), .err1(err1),
    .valid(valid), .addr_out(addr_out), .data_out(data_out), .gnt(gnt)
  );

  typedef struct packed {logic [7:0] a; logic [15:0] d;} beat_t;
  beat_t sbq[$];
  int checks = 0, fails = 0;
  int n_beats[2], sent[2];
  logic [7:0]  abase[2];
  logic [15:0] dbase[2];
  logic s_ack0, s_ack1, s_err1, s_valid;
  logic [1:0] s_gnt;
`ifdef BUS_ARB_ADDR_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_beats(input logic [7:0] a, input logic [15:0] d, input int cnt);
    beat_t b;
    for (int i = 0; i < cnt; i++) begin
      b.a = a + 8'(i);
      b.d = d + 16'(i);
      sbq.push_back(b);
    end
  endtask

  task automatic start_req(input int r, input int n, input logic [7:0] a, input logic [15:0] d);
    n_beats[r] = n; sent[r] = 0; abase[r] = a; dbase[r] = d;
    if (r == 0) begin req0 = (n > 0); addr0 = a; data0 = d; end
    else        begin req1 = (n > 0); addr1 = a; data1 = d; end
  endtask

  task automatic adv(input int r);
    sent[r]++;
    if (r == 0) begin
      if (sent[0] >= n_beats[0]) req0 = 1'b0;
      else begin addr0 = abase[0] + 8'(sent[0]); data0 = dbase[0] + 16'(sent[0]); end
    end else begin
      if (sent[1] >= n_beats[1]) req1 = 1'b0;
      else begin addr1 = abase[1] + 8'(sent[1]); data1 = dbase[1] + 16'(sent[1]); end
    end
  endtask

  // One cycle: sample mid-cycle, score any valid beat, then let requesters react to acks.
  task automatic step();
    beat_t e;
    @(negedge clk);
    s_valid = valid; s_ack0 = ack0; s_ack1 = ack1; s_err1 = err1; s_gnt = gnt;
    if (valid) begin
      if (sbq.size() == 0) chk("unexp_valid", valid, 1'b0);
      else begin
        e = sbq.pop_front();
        chk("addr_out", addr_out, e.a);
        chk("data_out", data_out, e.d);
      end
    end
    chk("ack_excl", ack0 & ack1, 1'b0);
    @(posedge clk); #1;
    if (s_ack0) adv(0);
    if (s_ack1) adv(1);
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (req0 || req1 || sbq.size() > 0); i++) step();
    chk("sb_empty", sbq.size(), 0);
    chk("req_done", {req1, req0}, 2'b00);
    step(); step();
    chk("idle_gnt", s_gnt, 2'b00);
  endtask

  initial begin
    reset = 1'b1;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; data0 = 0; data1 = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_valid", valid, 1'b0);
    chk("rst_addr", addr_out, 8'h00);
    chk("rst_data", data_out, 16'h0000);
    chk("rst_acks", {ack1, ack0, err1, err0}, 4'h0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Contention: both held, 4-beat bursts alternate starting with requester 0
    start_req(0, 8, 8'h20, 16'h2000);
    start_req(1, 8, 8'h40, 16'h4000);
    push_beats(8'h20, 16'h2000, 4); push_beats(8'h40, 16'h4000, 4);
    push_beats(8'h24, 16'h2004, 4); push_beats(8'h44, 16'h4004, 4);
    step();
    chk("idle_noack", {s_ack1, s_ack0}, 2'b00);
    for (int k = 0; k < 16; k++) begin
      step();
      chk("cont_ack0", s_ack0, ((k / 4) % 2) == 0);
      chk("cont_ack1", s_ack1, ((k / 4) % 2) == 1);
    end
    drain();

    // Single requester, 6 back-to-back beats
    start_req(0, 6, 8'h10, 16'hA000);
    push_beats(8'h10, 16'hA000, 6);
    step();
    chk("single_idle_gnt", s_gnt, 2'b00);
    chk("single_idle_ack", s_ack0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step();
      chk("single_gnt", s_gnt, 2'b01);
      chk("single_ack", s_ack0, 1'b1);
      if (k > 0) chk("single_valid", s_valid, 1'b1);
    end
    step();
    chk("single_valid_last", s_valid, 1'b1);
    step();
    chk("single_valid_end", s_valid, 1'b0);
    drain();

    // Address 8'h3F beat from requester 1
    start_req(1, 1, 8'h3F, 16'hBEEF);
    if (!CHK_EN) push_beats(8'h3F, 16'hBEEF, 1);
    step();
    step();
    chk("3f_gnt", s_gnt, 2'b10);
    chk("3f_ack1", s_ack1, 1'b1);
    chk("3f_err1", s_err1, CHK_EN);
    step();
    chk("3f_valid", s_valid, !CHK_EN);
    drain();

    // Tie from IDLE after requester 1 owned last: requester 0 first
    start_req(0, 1, 8'h70, 16'h7000);
    start_req(1, 1, 8'h78, 16'h7800);
    push_beats(8'h70, 16'h7000, 1); push_beats(8'h78, 16'h7800, 1);
    step();
    step();
    chk("tie_gnt", s_gnt, 2'b01);
    chk("tie_ack", {s_ack1, s_ack0}, 2'b01);
    step();
    chk("tie_rel_gnt", s_gnt, 2'b01);
    chk("tie_rel_ack", {s_ack1, s_ack0}, 2'b00);
    step();
    chk("tie_hand_gnt", s_gnt, 2'b10);
    chk("tie_hand_ack", s_ack1, 1'b1);
    drain();

    // Early release: requester 0 stops after 2 beats, ownership moves straight to 1
    start_req(0, 2, 8'h50, 16'h5000);
    start_req(1, 1, 8'h58, 16'h5800);
    push_beats(8'h50, 16'h5000, 2); push_beats(8'h58, 16'h5800, 1);
    step();
    step(); chk("early_ack0a", s_ack0, 1'b1);
    step(); chk("early_ack0b", s_ack0, 1'b1);
    step();
    chk("early_gap_gnt", s_gnt, 2'b01);
    chk("early_gap_ack", {s_ack1, s_ack0}, 2'b00);
    step();
    chk("early_own1", s_gnt, 2'b10);
    chk("early_ack1", s_ack1, 1'b1);
    step();
    chk("early_valid", s_valid, 1'b1);
    drain();

    // Reset mid-burst discards the in-flight beat; restart ties to requester 0
    start_req(0, 10, 8'h60, 16'h6000);
    push_beats(8'h60, 16'h6000, 1);
    step(); step(); step();
    reset = 1'b1;
    #1;
    chk("mid_rst_gnt", gnt, 2'b00);
    chk("mid_rst_valid", valid, 1'b0);
    chk("mid_rst_addr", addr_out, 8'h00);
    chk("mid_rst_data", data_out, 16'h0000);
    chk("mid_rst_ack", {ack1, ack0}, 2'b00);
    chk("mid_rst_sb", sbq.size(), 0);
    start_req(0, 1, 8'h90, 16'h9000);
    start_req(1, 1, 8'h98, 16'h9800);
    push_beats(8'h90, 16'h9000, 1); push_beats(8'h98, 16'h9800, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    step();
    chk("post_rst_gnt", s_gnt, 2'b01);
    chk("post_rst_ack", {s_ack1, s_ack0}, 2'b01);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter BURST_MAX, default 4, legal 1..15; max consecutive beats one requester may transfer per grant.
REQ-002 SHALL have clk  input  1  sole clock; all state on rising edge.
REQ-003 SHALL have reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have req0  input  1  requester 0 beat request; addr0  input  8  beat address; data0  input  16  beat data.
REQ-005 SHALL have ack0  output  1  beat accepted (combinational); err0  output  1  beat rejected (combinational).
REQ-006 SHALL have req1/addr1/data1/ack1/err1, identical to REQ-004..005, for requester 1.
REQ-007 SHALL have valid  output  1  registered one-cycle beat strobe to the bus switch; addr_out  output  8  and data_out  output  16  registered beat payload.
REQ-008 SHALL have gnt  output  2  registered one-hot current owner; 2'b00 when idle.

Function
REQ-009 SHALL implement FSM IDLE, OWN0, OWN1; gnt = 2'b01 in OWN0, 2'b10 in OWN1, 2'b00 in IDLE.
REQ-010 IDLE: req0 only -> OWN0; req1 only -> OWN1; both -> the requester not in last_owner; none -> stay. No ack in IDLE.
REQ-011 ackx SHALL be (state==OWNx) & reqx; a beat transfers on each rising edge where ackx=1.
REQ-012 Accepted beat SHALL appear as valid=1, addr_out=addrx, data_out=datax in the cycle after the accepting edge (latency 1); valid=0 otherwise, addr_out/data_out holding the last value.
REQ-013 4-bit beat counter SHALL increment per accepted beat in OWNx and clear on every state change.
REQ-014 OWNx, beat accepted with counter==BURST_MAX-1: reqy high -> OWNy; else stay in OWNx with counter cleared.
REQ-015 OWNx with reqx low at the edge: reqy high -> OWNy (no idle gap); else -> IDLE.
REQ-016 last_owner SHALL update to x on every entry into OWNx.
REQ-017 Requester SHALL hold reqx/addrx/datax stable until ackx; the arbiter never drops or duplicates a beat.
REQ-018 At most one of ack0/ack1 SHALL be high in any cycle.

Reset
REQ-019 reset high SHALL immediately force state=IDLE, gnt=2'b00, valid=0, addr_out=8'h00, data_out=16'h0000, counter=0, last_owner=1 (requester 0 wins first tie); ack0/ack1/err0/err1 low.
REQ-020 Reset mid-burst SHALL discard the in-flight beat; after release arbitration restarts from IDLE.

Configuration
REQ-021 With macro BUS_ARB_ADDR_CHECK_EN defined: a beat in OWNx with addrx==8'h3F SHALL give ackx=1 and errx=1 in the same cycle, produce no valid, and count toward BURST_MAX.
REQ-022 Without BUS_ARB_ADDR_CHECK_EN: err0/err1 SHALL be constant 0 and 8'h3F beats are forwarded as normal.

Verification
REQ-023 Reset: assert reset mid-burst with req0=1 -> same cycle gnt=00, valid=0, addr_out=00, data_out=0000; after release with req0=req1=1 -> OWN0 first.
REQ-024 Single requester: req0=1 held, addr0=8'h10..8'h15 advanced on each ack0 -> valid for 6 consecutive cycles, addr_out 10..15 in order, gnt=01 throughout, each one cycle after the accepting edge.
REQ-025 Contention, BURST_MAX=4: req0 and req1 held continuously -> 4 beats from 0, then 4 from 1, alternating, with no idle cycle between owners and ack0 & ack1 never both high.
REQ-026 Early release: OWN0 with req1=1, req0 drops after 2 beats -> next edge OWN1, data_out shows data1 one cycle later.
REQ-027 Address check, macro defined: req1=1, addr1=8'h3F, data1=16'hBEEF -> ack1=err1=1, valid stays 0; macro undefined -> err1=0, valid=1, addr_out=3F, data_out=BEEF.
REQ-028 Tie from IDLE after requester 1 last owned: req0=req1=1 rise together -> gnt=01.
